// File: rtl/v_state_table.sv
// Per-context state store: one write port, one update read port and NQ query
// read ports, each backed by its own 1R1W copy, with a self-managed init sweep.
module v_state_table #(
  parameter int             N        = 64,
  parameter int             W        = 32,
  parameter int             NQ       = 2,
  parameter logic [W-1:0]   INIT_VAL = '0,
  localparam int            AW       = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_init,
  output logic              o_busy_r,
  input  logic              i_wen,
  input  logic [AW-1:0]     i_waddr,
  input  logic [W-1:0]      i_wdata,
  output logic              o_wr_drop_r,
  input  logic              i_upd_ren,
  input  logic [AW-1:0]     i_upd_raddr,
  output logic              o_upd_rvld_r,
  output logic [W-1:0]      o_upd_rdata_r,
  input  logic [NQ-1:0]     i_lut_ren,
  input  logic [NQ*AW-1:0]  i_lut_raddr,
  output logic [NQ-1:0]     o_lut_rvld_r,
  output logic [NQ*W-1:0]   o_lut_rdata_r,
  output logic [NQ-1:0]     o_lut_err_r
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);
  localparam int            NP   = NQ + 1;

  logic          busy_r;
  logic [AW-1:0] ptr_r;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [W-1:0]  mem_wdata;

  logic          rd_en     [NP];
  logic [AW-1:0] rd_addr   [NP];
  logic          rd_vld_r  [NP];
  logic [W-1:0]  rd_data_r [NP];

  // Soft init restarts the sweep from entry 0 even if one is already running.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b1;
      ptr_r  <= '0;
    end else if (i_init) begin
      busy_r <= 1'b1;
      ptr_r  <= '0;
    end else if (busy_r) begin
      if (ptr_r == LAST) begin
        busy_r <= 1'b0;
        ptr_r  <= '0;
      end else begin
        ptr_r <= ptr_r + AW'(1);
      end
    end
  end

  // The sweep owns the write port while busy; user writes are dropped then.
  assign mem_we    = ~rst & (busy_r | i_wen);
  assign mem_waddr = busy_r ? ptr_r : i_waddr;
  assign mem_wdata = busy_r ? INIT_VAL : i_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      o_wr_drop_r <= 1'b0;
      o_lut_err_r <= '0;
    end else begin
      o_wr_drop_r <= i_wen & busy_r;
      o_lut_err_r <= i_lut_ren & {NQ{busy_r}};
    end
  end

  assign rd_en[0]   = i_upd_ren;
  assign rd_addr[0] = i_upd_raddr;

  for (genvar q = 0; q < NQ; q++) begin : g_lut
    assign rd_en[q+1]               = i_lut_ren[q];
    assign rd_addr[q+1]             = i_lut_raddr[q*AW +: AW];
    assign o_lut_rvld_r[q]          = rd_vld_r[q+1];
    assign o_lut_rdata_r[q*W +: W]  = rd_data_r[q+1];
  end

  for (genvar p = 0; p < NP; p++) begin : g_copy
    logic [W-1:0] mem [N];

    always_ff @(posedge clk) begin
      if (mem_we) begin
        mem[mem_waddr] <= mem_wdata;
      end
    end

    // Write-first bypass so callers never see stale data on an address collision.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_vld_r[p]  <= 1'b0;
        rd_data_r[p] <= '0;
      end else begin
        rd_vld_r[p] <= rd_en[p];
        if (rd_en[p]) begin
          rd_data_r[p] <= (mem_we && (mem_waddr == rd_addr[p])) ? mem_wdata
                                                                 : mem[rd_addr[p]];
        end
      end
    end
  end

  assign o_busy_r      = busy_r;
  assign o_upd_rvld_r  = rd_vld_r[0];
  assign o_upd_rdata_r = rd_data_r[0];

endmodule

// File: tb/tb_v_state_table.sv
// Randomised and directed bench for v_state_table against an array-based
// model of the store, the init sweep countdown and write-first reads.
module tb_v_state_table;

  localparam int          N  = 16;
  localparam int          W  = 8;
  localparam int          NQ = 2;
  localparam int          AW = 4;
  localparam logic [7:0]  IV = 8'hA5;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_init;
  logic              o_busy_r;
  logic              i_wen;
  logic [AW-1:0]     i_waddr;
  logic [W-1:0]      i_wdata;
  logic              o_wr_drop_r;
  logic              i_upd_ren;
  logic [AW-1:0]     i_upd_raddr;
  logic              o_upd_rvld_r;
  logic [W-1:0]      o_upd_rdata_r;
  logic [NQ-1:0]     i_lut_ren;
  logic [NQ*AW-1:0]  i_lut_raddr;
  logic [NQ-1:0]     o_lut_rvld_r;
  logic [NQ*W-1:0]   o_lut_rdata_r;
  logic [NQ-1:0]     o_lut_err_r;

  always #5 clk = ~clk;

  v_state_table #(.N(N), .W(W), .NQ(NQ), .INIT_VAL(IV)) dut (
    .clk(clk), .rst(rst), .i_init(i_init), .o_busy_r(o_busy_r),
    .i_wen(i_wen), .i_waddr(i_waddr), .i_wdata(i_wdata), .o_wr_drop_r(o_wr_drop_r),
    .i_upd_ren(i_upd_ren), .i_upd_raddr(i_upd_raddr),
    .o_upd_rvld_r(o_upd_rvld_r), .o_upd_rdata_r(o_upd_rdata_r),
    .i_lut_ren(i_lut_ren), .i_lut_raddr(i_lut_raddr),
    .o_lut_rvld_r(o_lut_rvld_r), .o_lut_rdata_r(o_lut_rdata_r), .o_lut_err_r(o_lut_err_r)
  );

  // Model: stored words with a known flag, and the number of sweep cycles left.
  logic [7:0] ref_mem   [N];
  bit         ref_known [N];
  int         sweep_left;
  logic [7:0] exp_upd_data;
  bit         exp_upd_known;
  logic [7:0] exp_lut_data  [NQ];
  bit         exp_lut_known [NQ];

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit s_rst, input bit s_init, input bit s_wen,
                               input logic [3:0] s_waddr, input logic [7:0] s_wdata,
                               input bit s_uren, input logic [3:0] s_uaddr,
                               input bit [1:0] s_lren, input logic [3:0] s_la0,
                               input logic [3:0] s_la1);
    bit         busy_now;
    bit         do_wr;
    int         wa;
    logic [7:0] wd;
    bit         exp_drop;
    bit [1:0]   exp_err;
    int         la [NQ];
    rst         = s_rst;
    i_init      = s_init;
    i_wen       = s_wen;
    i_waddr     = s_waddr;
    i_wdata     = s_wdata;
    i_upd_ren   = s_uren;
    i_upd_raddr = s_uaddr;
    i_lut_ren   = s_lren;
    i_lut_raddr = {s_la1, s_la0};
    la[0] = int'(s_la0);
    la[1] = int'(s_la1);
    busy_now = (sweep_left > 0);
    exp_drop = 1'b0;
    exp_err  = 2'b00;
    if (s_rst) begin
      exp_upd_data  = 8'h00;
      exp_upd_known = 1'b1;
      for (int q = 0; q < NQ; q++) begin
        exp_lut_data[q]  = 8'h00;
        exp_lut_known[q] = 1'b1;
      end
      sweep_left = N;
    end else begin
      do_wr = busy_now || s_wen;
      wa    = busy_now ? (N - sweep_left) : int'(s_waddr);
      wd    = busy_now ? IV : s_wdata;
      if (s_uren) begin
        if (do_wr && wa == int'(s_uaddr)) begin
          exp_upd_data = wd; exp_upd_known = 1'b1;
        end else begin
          exp_upd_data = ref_mem[s_uaddr]; exp_upd_known = ref_known[s_uaddr];
        end
      end
      for (int q = 0; q < NQ; q++) begin
        if (s_lren[q]) begin
          if (do_wr && wa == la[q]) begin
            exp_lut_data[q] = wd; exp_lut_known[q] = 1'b1;
          end else begin
            exp_lut_data[q] = ref_mem[la[q]]; exp_lut_known[q] = ref_known[la[q]];
          end
          if (busy_now) exp_lut_known[q] = 1'b0;
        end
      end
      exp_drop = s_wen && busy_now;
      exp_err  = s_lren & {2{busy_now}};
      if (do_wr) begin
        ref_mem[wa]   = wd;
        ref_known[wa] = 1'b1;
      end
      if (s_init) sweep_left = N;
      else if (sweep_left > 0) sweep_left--;
    end
    @(posedge clk);
    #1;
    checkOutput("busy", o_busy_r, (s_rst || sweep_left > 0));
    checkOutput("wr_drop", o_wr_drop_r, exp_drop);
    checkOutput("upd_vld", o_upd_rvld_r, (s_uren && !s_rst));
    checkOutput("lut_vld", o_lut_rvld_r, (s_rst ? 2'b00 : s_lren));
    checkOutput("lut_err", o_lut_err_r, exp_err);
    if (exp_upd_known) checkOutput("upd_data", o_upd_rdata_r, exp_upd_data);
    for (int q = 0; q < NQ; q++) begin
      if (exp_lut_known[q]) checkOutput($sformatf("lut%0d_data", q), o_lut_rdata_r[q*W +: W], exp_lut_data[q]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  task automatic countBusy(output int cnt);
    cnt = 0;
    while (o_busy_r && cnt < 100) begin
      idle(1);
      cnt++;
    end
  endtask

  int busy_cnt;

  initial begin
    for (int i = 0; i < N; i++) ref_known[i] = 1'b0;
    exp_upd_known = 1'b0;
    for (int q = 0; q < NQ; q++) exp_lut_known[q] = 1'b0;
    sweep_left = N;

    // Reset, then a full sweep, then every entry holds the init value.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 1, 0, 2'b11, 0, 0);
    checkOutput("reset_upd_data", o_upd_rdata_r, 8'h00);
    countBusy(busy_cnt);
    checkOutput("sweep_len", busy_cnt, N);
    for (int a = 0; a < N; a++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b11, 4'(a), 4'(N - 1 - a));
      checkOutput("init_val", o_lut_rdata_r[7:0], IV);
    end

    // Write-first collision on one query port, neighbour unaffected.
    applyStimulus(0, 0, 1, 4'd3, 8'h11, 0, 0, 2'b11, 4'd3, 4'd4);
    checkOutput("wf_p0", o_lut_rdata_r[7:0], 8'h11);
    checkOutput("wf_p1", o_lut_rdata_r[15:8], IV);
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd3, 2'b00, 0, 0);
    checkOutput("upd_after_wr", o_upd_rdata_r, 8'h11);

    // Dropped write and errored query during a sweep.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    idle(3);
    applyStimulus(0, 0, 1, 4'd7, 8'h22, 0, 0, 2'b10, 0, 4'd5);
    checkOutput("drop_pulse", o_wr_drop_r, 1'b1);
    checkOutput("busy_err1", o_lut_err_r[1], 1'b1);
    checkOutput("busy_vld0", o_lut_rvld_r[0], 1'b0);
    countBusy(busy_cnt);
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd7, 2'b00, 0, 0);
    checkOutput("dropped_addr7", o_upd_rdata_r, IV);

    // Soft init restarted mid-sweep.
    applyStimulus(0, 0, 1, 4'd9, 8'h33, 0, 0, 2'b00, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    idle(9);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    countBusy(busy_cnt);
    checkOutput("restart_len", busy_cnt, N);
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd9, 2'b00, 0, 0);
    checkOutput("restart_addr9", o_upd_rdata_r, IV);

    // Reset mid-sweep with a write attempt that must not land.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    idle(5);
    applyStimulus(1, 0, 1, 4'd2, 8'h77, 1, 4'd2, 2'b11, 4'd2, 4'd2);
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd2, 2'b00, 0, 0);
    checkOutput("rst_no_write", o_upd_rdata_r, IV);
    countBusy(busy_cnt);
    checkOutput("post_rst_len", busy_cnt, N - 1);

    // Random traffic with occasional soft init and reset.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                    bit'($urandom_range(0, 1)), 4'($urandom), 8'($urandom),
                    bit'($urandom_range(0, 1)), 4'($urandom), 2'($urandom),
                    4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
